flag_status_register: RTL and testbench

// - Sits directly downstream of the ALU flag generator; registers its Z/N/V/C outputs as the architectural NZCV status.
// - Evaluates a 4-bit condition code against the registered NZCV for conditional execution/branching.
// - Buffers every flag snapshot in a small FIFO drained by the board display/debug logic.
// - Keeps a saturating count of overflow events.

---
 rtl/flag_status_register.sv | 189 ++++++++++++++++++
 tb/tb_flag_status_register.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_status_register.sv
// flag_status_register
// Registers the ALU Z/N/V/C flags as the architectural NZCV status, evaluates
// ARM-style condition codes against them, buffers every captured flag snapshot
// in a small FIFO for display/debug, and keeps a saturating overflow count.
// Optional feature: define FLAG_STICKY_EN to build the sticky-overflow flop
// (v_sticky / clr_sticky); otherwise v_sticky is tied low.
module flag_status_register #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Z,
    input  logic             N,
    input  logic             V,
    input  logic             C,
    input  logic             in_valid,
    input  logic             flag_we,
    output logic             in_ready,
    input  logic [3:0]       cond,
    output logic             cond_pass,
    output logic [3:0]       nzcv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_nzcv,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_sticky,
    output logic             v_sticky
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Condition-code evaluation against a {N,Z,C,V} word; 4'hF is reserved.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic fn;
        logic fz;
        logic fc;
        logic fv;
        logic res;
        fn = f[3];
        fz = f[2];
        fc = f[1];
        fv = f[0];
        case (cc)
            4'h0:    res = fz;
            4'h1:    res = ~fz;
            4'h2:    res = fc;
            4'h3:    res = ~fc;
            4'h4:    res = fn;
            4'h5:    res = ~fn;
            4'h6:    res = fv;
            4'h7:    res = ~fv;
            4'h8:    res = fc & ~fz;
            4'h9:    res = ~fc | fz;
            4'hA:    res = (fn == fv);
            4'hB:    res = (fn != fv);
            4'hC:    res = ~fz & (fn == fv);
            4'hD:    res = fz | (fn != fv);
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0]       nzcv_q;
    logic [3:0]       nzcv_d;
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   rd_ptr_d;
    logic [3:0]       mem_q [DEPTH];
    logic [CNT_W-1:0] ovf_q;
    logic [CNT_W-1:0] ovf_d;

    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             pop_s;
    logic [3:0]       flags_in_s;

    // The extra wrap bit tells full (same index, different lap) from empty.
    assign full_s     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign accept_s   = in_valid & flag_we & ~full_s;
    assign pop_s      = ~empty_s & out_ready;
    assign flags_in_s = {N, Z, C, V};

    assign in_ready   = ~full_s;
    assign out_valid  = ~empty_s;
    assign nzcv       = nzcv_q;
    assign ovf_count  = ovf_q;

    // Head is read straight from the storage registers; forced to zero when empty.
    always_comb begin
        if (empty_s) begin
            out_nzcv = 4'b0000;
        end else begin
            out_nzcv = mem_q[rd_ptr_q[PTR_W-1:0]];
        end
    end

    // Condition pass is a pure decode of the registered flags.
    always_comb begin
        cond_pass = cond_eval(cond, nzcv_q);
    end

    // Next-state for flags, pointers and the saturating overflow counter.
    always_comb begin
        nzcv_d   = nzcv_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (accept_s) begin
            nzcv_d   = flags_in_s;
            wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end else begin
            nzcv_d   = nzcv_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (accept_s && V && (ovf_q != {CNT_W{1'b1}})) begin
            ovf_d = ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Architectural state; reset discards FIFO contents and beats any same-cycle accept/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nzcv_q   <= 4'b0000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            nzcv_q   <= nzcv_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Snapshot storage; an entry is written only on an accepted capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'b0000;
            end
        end else if (accept_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= flags_in_s;
        end
    end

`ifdef FLAG_STICKY_EN
    logic v_sticky_q;
    logic v_sticky_d;

    // Sticky overflow: a setting accept wins over a same-cycle clear.
    always_comb begin
        if (accept_s && V) begin
            v_sticky_d = 1'b1;
        end else if (clr_sticky) begin
            v_sticky_d = 1'b0;
        end else begin
            v_sticky_d = v_sticky_q;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_sticky_q <= 1'b0;
        end else begin
            v_sticky_q <= v_sticky_d;
        end
    end

    assign v_sticky = v_sticky_q;
`else
    logic unused_clr_sticky_s;
    assign unused_clr_sticky_s = clr_sticky;
    assign v_sticky            = 1'b0;
`endif

endmodule

// File: tb/tb_flag_status_register.sv
// Directed bench for flag_status_register with a snapshot scoreboard.
// Stimulus pushes the expected snapshot when it issues a capture that must be
// accepted; an independent monitor pops and compares on every FIFO hand-off.
module tb_flag_status_register;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
`ifdef FLAG_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             z = 1'b0;
    logic             n = 1'b0;
    logic             v = 1'b0;
    logic             c = 1'b0;
    logic             in_valid = 1'b0;
    logic             flag_we = 1'b0;
    logic             in_ready;
    logic [3:0]       cond = 4'hE;
    logic             cond_pass;
    logic [3:0]       nzcv;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_nzcv;
    logic [CNT_W-1:0] ovf_count;
    logic             clr_sticky = 1'b0;
    logic             v_sticky;

    logic [3:0]       exp_q [$];
    logic [3:0]       mon_exp;
    int               n_cmp = 0;
    int               n_bad = 0;

    always #5 clk = ~clk;

    flag_status_register #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Z(z), .N(n), .V(v), .C(c),
        .in_valid(in_valid), .flag_we(flag_we), .in_ready(in_ready),
        .cond(cond), .cond_pass(cond_pass), .nzcv(nzcv),
        .out_valid(out_valid), .out_ready(out_ready), .out_nzcv(out_nzcv),
        .ovf_count(ovf_count), .clr_sticky(clr_sticky), .v_sticky(v_sticky)
    );

    // Monitor: every hand-off seen before the edge is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got %b, required no entry", out_nzcv);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_nzcv !== mon_exp) begin
                    n_bad++;
                    $display("FAIL pop_order: got %b, required %b", out_nzcv, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cond(input logic [3:0] cc, input logic exp);
        cond = cc;
        #1;
        chk($sformatf("cond_%h", cc), 8'(cond_pass), 8'(exp));
    endtask

    // One cycle of stimulus, aligned one step after a rising edge, then back to idle.
    task automatic step(input logic [3:0] f, input logic iv, input logic we,
                        input logic ordy, input logic clr, input logic rstv,
                        input logic exp_acc);
        @(posedge clk);
        #1;
        {n, z, c, v} = f;
        in_valid   = iv;
        flag_we    = we;
        out_ready  = ordy;
        clr_sticky = clr;
        rst_n      = rstv;
        if (exp_acc) exp_q.push_back(f);
        @(posedge clk);
        #1;
        if (!rstv) exp_q.delete();
        in_valid   = 1'b0;
        flag_we    = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic acc(input logic [3:0] f, input logic ordy, input logic exp_acc);
        step(f, 1'b1, 1'b1, ordy, 1'b0, 1'b1, exp_acc);
    endtask

    task automatic idle(input logic ordy);
        step(4'b0000, 1'b0, 1'b0, ordy, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (out_valid) idle(1'b1);
        end
        chk("drain_done", 8'(out_valid), 8'h00);
    endtask

    initial begin
        // Reset then idle
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_nzcv", 8'(nzcv), 8'h00);
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        chk("rst_in_ready", 8'(in_ready), 8'h01);
        chk("rst_ovf", 8'(ovf_count), 8'h00);
        chk("rst_sticky", 8'(v_sticky), 8'h00);
        chk("rst_out_nzcv", 8'(out_nzcv), 8'h00);
        chk_cond(4'hE, 1'b1);

        // Z=1 C=1 -> {N,Z,C,V}=0110
        acc(4'b0110, 1'b0, 1'b1);
        chk("nzcv_0110", 8'(nzcv), 8'h06);
        chk("out_valid_1", 8'(out_valid), 8'h01);
        chk("head_0110", 8'(out_nzcv), 8'h06);
        chk_cond(4'h0, 1'b1);
        chk_cond(4'h1, 1'b0);
        chk_cond(4'h8, 1'b0);
        chk_cond(4'h9, 1'b1);
        chk_cond(4'hF, 1'b0);

        // in_valid without flag_we changes nothing
        step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("nowe_nzcv", 8'(nzcv), 8'h06);
        chk("nowe_ovf", 8'(ovf_count), 8'h00);
        drain();

        // Fill to DEPTH, fifth capture refused
        acc(4'b1000, 1'b0, 1'b1);
        acc(4'b0100, 1'b0, 1'b1);
        acc(4'b0010, 1'b0, 1'b1);
        chk("ready_occ3", 8'(in_ready), 8'h01);
        acc(4'b1001, 1'b0, 1'b1);
        chk("ready_full", 8'(in_ready), 8'h00);
        chk("ovf_1", 8'(ovf_count), 8'h01);
        acc(4'b0111, 1'b0, 1'b0);
        chk("full_nzcv_held", 8'(nzcv), 8'h09);
        chk("full_ovf_held", 8'(ovf_count), 8'h01);
        chk("full_head_stable", 8'(out_nzcv), 8'h08);
        chk_cond(4'hA, 1'b1);
        chk_cond(4'hB, 1'b0);
        chk_cond(4'hC, 1'b1);
        chk_cond(4'hD, 1'b0);
        chk_cond(4'h4, 1'b1);
        chk_cond(4'h6, 1'b1);
        chk_cond(4'h7, 1'b0);

        // Full with out_ready: pop only, 4 -> 3
        acc(4'b0111, 1'b1, 1'b0);
        chk("full_pop_ready", 8'(in_ready), 8'h01);
        chk("full_pop_nzcv", 8'(nzcv), 8'h09);
        idle(1'b1);

        // Push and pop together at occupancy 2
        acc(4'b0011, 1'b1, 1'b1);
        chk("pp_nzcv", 8'(nzcv), 8'h03);
        chk("ovf_2", 8'(ovf_count), 8'h02);
        chk("pp_ready", 8'(in_ready), 8'h01);
        acc(4'b1101, 1'b1, 1'b1);
        chk("ovf_3", 8'(ovf_count), 8'h03);
        acc(4'b0001, 1'b0, 1'b1);
        chk("ovf_sat_a", 8'(ovf_count), 8'h03);
        acc(4'b1011, 1'b0, 1'b1);
        chk("ovf_sat_b", 8'(ovf_count), 8'h03);
        chk("pp_full", 8'(in_ready), 8'h00);
        chk("sticky_set", 8'(v_sticky), 8'(STK));
        idle(1'b1);

        // Sticky clear, then clear racing a setting accept
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sticky_clr", 8'(v_sticky), 8'h00);
        step(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("sticky_set_wins", 8'(v_sticky), 8'(STK));
        chk("ovf_sat_c", 8'(ovf_count), 8'h03);
        idle(1'b1);

        // Reset with 3 entries, accept and pop requested
        step(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mrst_nzcv", 8'(nzcv), 8'h00);
        chk("mrst_out_valid", 8'(out_valid), 8'h00);
        chk("mrst_out_nzcv", 8'(out_nzcv), 8'h00);
        chk("mrst_in_ready", 8'(in_ready), 8'h01);
        chk("mrst_ovf", 8'(ovf_count), 8'h00);
        chk("mrst_sticky", 8'(v_sticky), 8'h00);

        // Normal operation after reset
        acc(4'b1110, 1'b0, 1'b1);
        chk("post_nzcv", 8'(nzcv), 8'h0E);
        chk("post_head", 8'(out_nzcv), 8'h0E);
        drain();
        chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
